// File: rtl/keccak_pkg.sv
// Shared constants and types for the keccak pipeline stages.
package keccak_pkg;

    localparam int w              = 64;
    localparam int LOG2_W         = 6;
    localparam int RATE_SHAKE128  = 1344;
    localparam int RATE_SHAKE256  = 1088;
    localparam int WORDS_SHAKE128 = 21;
    localparam int WORDS_SHAKE256 = 17;

    typedef enum logic [1:0] {
        MODE_SHAKE128 = 2'b00,
        MODE_SHAKE256 = 2'b01,
        MODE_RSVD2    = 2'b10,
        MODE_RSVD3    = 2'b11
    } mode_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } dump_state_t;

    // Rate words per squeezed block; reserved modes fall back to the narrower rate.
    function automatic logic [4:0] block_words(input mode_t m);
        case (m)
            MODE_SHAKE128: block_words = 5'(WORDS_SHAKE128);
            MODE_SHAKE256: block_words = 5'(WORDS_SHAKE256);
            default:       block_words = 5'(WORDS_SHAKE256);
        endcase
    endfunction

    // Keeps the low tail bits of the final word; a zero tail means a full word.
    function automatic logic [w-1:0] tail_mask(input logic [LOG2_W-1:0] tail);
        if (tail == 6'd0) begin
            tail_mask = {w{1'b1}};
        end else begin
            tail_mask = (64'd1 << tail) - 64'd1;
        end
    endfunction

endpackage

// File: rtl/dump_stage.sv
// Squeeze/output stage: captures one rate block from permute_stage and streams it
// out as w-bit words over a valid/ready handshake until the requested length is sent.
module dump_stage
    import keccak_pkg::*;
#(
    parameter int W_OUT_SIZE = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RATE_SHAKE128-1:0] rate_output,
    input  logic                     output_buffer_we,
    input  logic [W_OUT_SIZE-1:0]    output_size,
    input  logic [1:0]               operation_mode,
    input  logic                     copy_control_regs_en,
    output logic                     output_buffer_ready,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [w-1:0]             data_out,
    output logic                     squeeze_done_o
);

    localparam int W_REM = W_OUT_SIZE - LOG2_W;

    dump_state_t              state;
    logic [RATE_SHAKE128-1:0] buffer;
    logic [4:0]               word_idx;
    logic [W_REM-1:0]         remaining;
    logic [LOG2_W-1:0]        tail_bits;
    mode_t                    mode;
    logic                     last_word;
    logic                     block_end;

    logic                     transfer;
    logic [W_REM-1:0]         rem_after;
    logic [W_REM-1:0]         size_words;
    logic [W_REM-1:0]         eff_remaining;

    assign transfer = valid_o & ready_i;

    // Done must coincide with the handshake of the final word, so it is gated by ready_i.
    assign squeeze_done_o = transfer & last_word;

    // Word count for a new request, saturating instead of wrapping at the top of the range.
    always_comb begin
        size_words = output_size[W_OUT_SIZE-1:LOG2_W];
        if ((output_size[LOG2_W-1:0] != 6'd0) && (size_words != {W_REM{1'b1}})) begin
            size_words = size_words + W_REM'(1);
        end else begin
            size_words = output_size[W_OUT_SIZE-1:LOG2_W];
        end
    end

    // Remaining count after this cycle's transfer, and the count a same-cycle write would see.
    always_comb begin
        rem_after     = remaining;
        eff_remaining = remaining;
        if (transfer && (remaining != {W_REM{1'b0}})) begin
            rem_after = remaining - W_REM'(1);
        end else begin
            rem_after = remaining;
        end
        if (copy_control_regs_en) begin
            eff_remaining = size_words;
        end else begin
            eff_remaining = remaining;
        end
    end

    // Buffer FSM, output word register and message counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= EMPTY;
            buffer              <= {RATE_SHAKE128{1'b0}};
            word_idx            <= 5'd0;
            remaining           <= {W_REM{1'b0}};
            tail_bits           <= 6'd0;
            mode                <= MODE_SHAKE128;
            last_word           <= 1'b0;
            block_end           <= 1'b0;
            valid_o             <= 1'b0;
            data_out            <= {w{1'b0}};
            output_buffer_ready <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (copy_control_regs_en) begin
                        remaining <= size_words;
                        tail_bits <= output_size[LOG2_W-1:0];
                        mode      <= mode_t'(operation_mode);
                    end
                    if (output_buffer_we && (eff_remaining != {W_REM{1'b0}})) begin
                        buffer              <= rate_output;
                        word_idx            <= 5'd0;
                        state               <= FULL;
                        output_buffer_ready <= 1'b0;
                    end
                end
                FULL: begin
                    remaining <= rem_after;
                    if ((transfer && (last_word || block_end)) ||
                        (!valid_o && (remaining == {W_REM{1'b0}}))) begin
                        // Unsent words of the block are discarded here.
                        state               <= EMPTY;
                        output_buffer_ready <= 1'b1;
                        valid_o             <= 1'b0;
                        data_out            <= {w{1'b0}};
                        last_word           <= 1'b0;
                        block_end           <= 1'b0;
                    end else if (!valid_o || transfer) begin
                        if (rem_after == W_REM'(1)) begin
                            data_out <= buffer[w-1:0] & tail_mask(tail_bits);
                        end else begin
                            data_out <= buffer[w-1:0];
                        end
                        buffer    <= buffer >> w;
                        valid_o   <= 1'b1;
                        last_word <= (rem_after == W_REM'(1));
                        block_end <= (word_idx == (block_words(mode) - 5'd1));
                        if (word_idx != 5'd31) begin
                            word_idx <= word_idx + 5'd1;
                        end
                    end
                end
                default: begin
                    state               <= EMPTY;
                    output_buffer_ready <= 1'b1;
                    valid_o             <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dump_stage.sv
// Directed bench for dump_stage with a word-stream reference model and per-cycle compare.
module tb_dump_stage;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1343:0] rate_output = '0;
    logic          output_buffer_we = 1'b0;
    logic [31:0]   output_size = 32'd0;
    logic [1:0]    operation_mode = 2'b00;
    logic          copy_control_regs_en = 1'b0;
    logic          output_buffer_ready;
    logic          ready_i = 1'b1;
    logic          valid_o;
    logic [63:0]   data_out;
    logic          squeeze_done_o;

    typedef struct {
        logic [63:0] d;
        bit          last;
    } exp_t;

    exp_t        expq[$];
    int          total = 0;
    int          bad = 0;
    int          words_seen = 0;
    int          done_cnt = 0;
    int          rnd_mode = 0;
    bit          obr_pending = 1'b0;
    logic [63:0] last_seen = '0;

    dump_stage #(.W_OUT_SIZE(32)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rate_output          (rate_output),
        .output_buffer_we     (output_buffer_we),
        .output_size          (output_size),
        .operation_mode       (operation_mode),
        .copy_control_regs_en (copy_control_regs_en),
        .output_buffer_ready  (output_buffer_ready),
        .ready_i              (ready_i),
        .valid_o              (valid_o),
        .data_out             (data_out),
        .squeeze_done_o       (squeeze_done_o)
    );

    always #5 clk = ~clk;

    // Downstream ready: 0 = always ready, 1 = random, 2 = held low.
    always @(posedge clk) begin
        #2;
        if (rnd_mode == 1)      ready_i = 1'($urandom_range(0, 1));
        else if (rnd_mode == 2) ready_i = 1'b0;
        else                    ready_i = 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] golden(input int b, input int k);
        logic [31:0] lo;
        lo = 32'((b + 1) * 32'h0100_0193) ^ 32'(k * 32'h9E37_79B9);
        return {8'(b + 1), 8'(k), 16'h5A3C, lo};
    endfunction

    function automatic logic [1343:0] make_block(input int b);
        logic [1343:0] v;
        v = '0;
        for (int k = 0; k < 21; k++) v[k*64 +: 64] = golden(b, k);
        return v;
    endfunction

    function automatic int wpb(input int mode);
        return (mode == 0) ? 21 : 17;
    endfunction

    // Expected message: word i comes from block i/wpb, slot i%wpb; final word tail-masked.
    task automatic build(input int mode, input int size);
        int n;
        exp_t e;
        n = (size + 63) / 64;
        expq.delete();
        for (int i = 0; i < n; i++) begin
            e.d = golden(i / wpb(mode), i % wpb(mode));
            if (i == n - 1 && (size % 64) != 0) e.d = e.d & ((64'd1 << (size % 64)) - 64'd1);
            e.last = (i == n - 1);
            expq.push_back(e);
        end
    endtask

    // Per-cycle compare against the model stream.
    always @(negedge clk) begin
        if (rst) begin
            obr_pending = 1'b0;
        end else begin
            if (obr_pending) begin
                chk("obr_after_done", 64'(output_buffer_ready), 64'd1);
                obr_pending = 1'b0;
            end
            if (valid_o) begin
                if (expq.size() == 0) begin
                    chk("spurious_valid", 64'(valid_o), 64'd0);
                end else begin
                    chk("data", data_out, expq[0].d);
                    if (ready_i) begin
                        chk("done", 64'(squeeze_done_o), 64'(expq[0].last));
                        if (expq[0].last) begin
                            done_cnt++;
                            obr_pending = 1'b1;
                            last_seen = data_out;
                        end
                        words_seen++;
                        void'(expq.pop_front());
                    end else begin
                        chk("done_stall", 64'(squeeze_done_o), 64'd0);
                    end
                end
            end else begin
                chk("done_idle", 64'(squeeze_done_o), 64'd0);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic latch(input int mode, input int size);
        operation_mode = 2'(mode);
        output_size = 32'(size);
        copy_control_regs_en = 1'b1;
        tick;
        copy_control_regs_en = 1'b0;
        build(mode, size);
        words_seen = 0;
        done_cnt = 0;
    endtask

    task automatic wait_obr;
        for (int i = 0; i < 3000 && output_buffer_ready !== 1'b1; i++) tick;
        chk("wait_obr", 64'(output_buffer_ready), 64'd1);
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 5000 && expq.size() != 0; i++) tick;
        chk(name, 64'(expq.size()), 64'd0);
    endtask

    task automatic write_block(input int b);
        rate_output = make_block(b);
        output_buffer_we = 1'b1;
        tick;
        output_buffer_we = 1'b0;
    endtask

    task automatic run_msg(input int mode, input int size, input int rmode, input int exp_words);
        int nblk;
        rnd_mode = rmode;
        latch(mode, size);
        nblk = (exp_words + wpb(mode) - 1) / wpb(mode);
        for (int b = 0; b < nblk; b++) begin
            wait_obr;
            write_block(b);
        end
        wait_empty("msg_drain");
        tick;
        chk("words_seen", 64'(words_seen), 64'(exp_words));
        chk("done_cnt", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_data", data_out, 64'd0);
        chk("rst_done", 64'(squeeze_done_o), 64'd0);
        chk("rst_obr", 64'(output_buffer_ready), 64'd1);
        rst = 1'b0;
        tick;

        // SHAKE128, 256 bits: latency pinned by hand, then four words with done on word 3.
        rnd_mode = 0;
        latch(0, 256);
        write_block(0);
        @(negedge clk);
        chk("lat_n0_valid", 64'(valid_o), 64'd0);
        tick;
        @(negedge clk);
        chk("lat_n1_valid", 64'(valid_o), 64'd1);
        chk("lat_n1_data", data_out, 64'h0100_5A3C_0100_0193);
        wait_empty("t1_drain");
        tick;
        chk("t1_words", 64'(words_seen), 64'd4);
        chk("t1_done", 64'(done_cnt), 64'd1);

        // SHAKE256, 1600 bits over two blocks.
        run_msg(1, 1600, 0, 25);

        // SHAKE128, 100 bits: last word keeps only 36 bits.
        run_msg(0, 100, 0, 2);
        chk("t3_tail_zero", 64'(last_seen[63:36]), 64'd0);

        // Random backpressure across a block boundary, and reserved mode.
        run_msg(0, 2000, 1, 32);
        run_msg(2, 1152, 1, 18);

        // output_size == 0: write dropped, nothing emitted.
        latch(0, 0);
        write_block(0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("zero_obr", 64'(output_buffer_ready), 64'd1);
            chk("zero_valid", 64'(valid_o), 64'd0);
        end

        // Write and control latch while FULL are ignored.
        rnd_mode = 2;
        tick;
        latch(0, 512);
        wait_obr;
        write_block(0);
        tick;
        tick;
        rate_output = make_block(7);
        output_buffer_we = 1'b1;
        output_size = 32'd64;
        operation_mode = 2'b01;
        copy_control_regs_en = 1'b1;
        tick;
        output_buffer_we = 1'b0;
        copy_control_regs_en = 1'b0;
        chk("full_obr", 64'(output_buffer_ready), 64'd0);
        chk("full_valid", 64'(valid_o), 64'd1);
        rnd_mode = 1;
        wait_empty("t5_drain");
        tick;
        chk("t5_words", 64'(words_seen), 64'd8);
        chk("t5_done", 64'(done_cnt), 64'd1);

        // Reset after word 5 of 21, then a clean message.
        rnd_mode = 0;
        tick;
        latch(0, 1344);
        wait_obr;
        write_block(0);
        for (int i = 0; i < 100 && words_seen < 5; i++) tick;
        chk("t6_reach5", 64'(words_seen), 64'd5);
        rst = 1'b1;
        #1;
        chk("t6_valid", 64'(valid_o), 64'd0);
        chk("t6_data", data_out, 64'd0);
        chk("t6_obr", 64'(output_buffer_ready), 64'd1);
        expq.delete();
        tick;
        rst = 1'b0;
        tick;
        run_msg(0, 256, 0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
